// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dumper: sizes, FSM state type, byte split.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Optional feature macro: REGDUMP_CHECKSUM_EN adds the SEND_CSUM state.
package regfile_pkg;

  localparam int REG_SEL_W  = 4;
  localparam int REG_DATA_W = 16;
  localparam int REG_COUNT  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_A,
    SEND_B,
`ifdef REGDUMP_CHECKSUM_EN
    SEND_CSUM,
`endif
    DONE
  } dump_state_t;

  // Returns the first (second=0) or second (second=1) byte of a word on the wire.
  // The high byte goes first exactly when msb_first is set.
  function automatic logic [7:0] split_byte(input logic [REG_DATA_W-1:0] word,
                                            input logic msb_first,
                                            input logic second);
    split_byte = (msb_first != second) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/regfile_dumper_if.sv
// Bundle between the dumper, the register file read port and the byte stream.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready byte stream; read port is combinational.
// Ports (master = dumper side):
//   start, first_sel, last_sel   dump request and inclusive register range
//   read_select, read_data       register file read port
//   out_data, out_valid, out_ready  byte stream
//   busy, done                   status
interface regfile_dumper_if
  import regfile_pkg::*;
#(
  parameter int SEL_W  = REG_SEL_W,
  parameter int DATA_W = REG_DATA_W
);
  logic              start;
  logic [SEL_W-1:0]  first_sel;
  logic [SEL_W-1:0]  last_sel;
  logic [SEL_W-1:0]  read_select;
  logic [DATA_W-1:0] read_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_sel, last_sel, read_data, out_ready,
    output read_select, out_data, out_valid, busy, done
  );

  modport slave (
    output start, first_sel, last_sel, read_data, out_ready,
    input  read_select, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/regfile_dumper.sv
// Walks a register range on start and streams each 16-bit word out as two bytes.
// Latency: first out_valid 2 cycles after start; 3 cycles per word with out_ready held high.
// Backpressure: out_data/out_valid held stable until out_ready; the walk stalls meanwhile.
// Ports: clk, reset_n (async active-low), bus (regfile_dumper_if.master).
// Optional feature macro: REGDUMP_CHECKSUM_EN appends an XOR checksum byte to each dump.
module regfile_dumper
  import regfile_pkg::*;
#(
  parameter int NUM_REGS  = REG_COUNT,
  parameter int SEL_W     = REG_SEL_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  regfile_dumper_if.master bus
);

  localparam logic MSB_BIT = (MSB_FIRST != 0);

  dump_state_t       state_q, state_nxt;
  logic [SEL_W-1:0]  read_select_q;
  logic [SEL_W-1:0]  last_sel_q;
  logic [DATA_W-1:0] word_q;
  logic [7:0]        out_data_c;
  logic              out_valid_c;
  logic              is_last;
  logic              byte_hs;

`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign is_last = (read_select_q == last_sel_q);
  assign byte_hs = out_valid_c && bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:   if (bus.start) state_nxt = FETCH;
      FETCH:  state_nxt = SEND_A;
      SEND_A: if (bus.out_ready) state_nxt = SEND_B;
      SEND_B: begin
        if (bus.out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          state_nxt = is_last ? SEND_CSUM : FETCH;
`else
          state_nxt = is_last ? DONE : FETCH;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      SEND_CSUM: if (bus.out_ready) state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: everything the stream sees is decoded from state plus held registers,
  // so out_data cannot move while a byte is waiting for out_ready.
  always_comb begin
    out_valid_c = 1'b0;
    out_data_c  = 8'h00;
    case (state_q)
      SEND_A: begin
        out_valid_c = 1'b1;
        out_data_c  = split_byte(word_q, MSB_BIT, 1'b0);
      end
      SEND_B: begin
        out_valid_c = 1'b1;
        out_data_c  = split_byte(word_q, MSB_BIT, 1'b1);
      end
`ifdef REGDUMP_CHECKSUM_EN
      SEND_CSUM: begin
        out_valid_c = 1'b1;
        out_data_c  = csum_q;
      end
`endif
      default: ;
    endcase
  end

  // Datapath: range latch, read pointer, word capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_select_q <= '0;
      last_sel_q    <= '0;
      word_q        <= '0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        read_select_q <= bus.first_sel;
        last_sel_q    <= bus.last_sel;
      end
      // Word is sampled once here; later register writes do not affect the bytes sent.
      if (state_q == FETCH) word_q <= bus.read_data;
      if (state_q == SEND_B && bus.out_ready && !is_last) begin
        read_select_q <= (read_select_q == SEL_W'(NUM_REGS - 1)) ? '0 : read_select_q + 1'b1;
      end
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  // Running XOR over the data bytes actually accepted in this dump.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      csum_q <= '0;
    end else if (byte_hs && (state_q == SEND_A || state_q == SEND_B)) begin
      csum_q <= csum_q ^ out_data_c;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = byte_hs;
`endif

  assign bus.read_select = read_select_q;
  assign bus.out_data    = out_data_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: expected bytes come from a range-walk model of the
// register array taken at start; a negedge monitor pops and compares every accepted byte.
module tb_regfile_dumper;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  regfile_dumper_if bus ();

  logic [15:0] rf [16];
  assign bus.read_data = rf[bus.read_select];

  regfile_dumper #(
    .NUM_REGS (16),
    .SEL_W    (4),
    .DATA_W   (16),
    .MSB_FIRST(1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] sb [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int ready_pct = 100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk first..last modulo 16, two bytes per word high first, optional XOR byte.
  task automatic expect_dump(input int first, input int last);
    int s;
    logic [7:0] x;
    s = first;
    x = 8'h00;
    forever begin
      sb.push_back(rf[s][15:8]);
      sb.push_back(rf[s][7:0]);
      x = x ^ rf[s][15:8] ^ rf[s][7:0];
      if (s == last) break;
      s = (s + 1) % 16;
    end
`ifdef REGDUMP_CHECKSUM_EN
    sb.push_back(x);
`endif
  endtask

  function automatic int nwords(input int first, input int last);
    return ((last - first + 16) % 16) + 1;
  endfunction

  // Ready driver
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: byte scoreboard, hold stability, done accounting
  initial begin : monitor
    logic       hold;
    logic [7:0] hold_dat;
    logic [7:0] e;
    hold = 1'b0;
    hold_dat = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(hold_dat));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected no byte", bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("byte", 32'(bus.out_data), 32'(e));
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      hold_dat = bus.out_data;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("sb_empty_at_done", 32'(sb.size()), 32'd0);
      end
    end
  end

  task automatic do_start(input int f, input int l, input bit model);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.first_sel = 4'(f);
    bus.last_sel = 4'(l);
    if (model) expect_dump(f, l);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    int f;
    int l;
    int exp_lat;
    bus.start = 1'b0;
    bus.first_sel = '0;
    bus.last_sel = '0;
    for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);

    // Reset state
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_read_select", 32'(bus.read_select), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    reset_n = 1'b1;

    // Full range, ready always high: latency and throughput
    ready_pct = 100;
    do_start(0, 15, 1'b1);
    chk("fetch_busy", 32'(bus.busy), 32'd1);
    chk("fetch_valid", 32'(bus.out_valid), 32'd0);
    chk("fetch_sel", 32'(bus.read_select), 32'd0);
    @(posedge clk);
    #1;
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_byte", 32'(bus.out_data), 32'hA0);
    wait_done(500);
    exp_lat = 3 * 16 + 1;
`ifdef REGDUMP_CHECKSUM_EN
    exp_lat = exp_lat + 1;
`endif
    chk("done_latency", 32'(done_cyc - start_cyc), 32'(exp_lat));
    @(posedge clk);
    #1;
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("done_pulse_one", 32'(bus.done), 32'd0);

    // Wrapping range 14..1
    rf[14] = 16'h1234; rf[15] = 16'h5678; rf[0] = 16'h9ABC; rf[1] = 16'hDEF0;
    ready_pct = 70;
    do_start(14, 1, 1'b1);
    wait_done(500);

    // Single register, sparse ready
    rf[5] = 16'hBEEF;
    ready_pct = 30;
    do_start(5, 5, 1'b1);
    wait_done(500);

    // Checksum example range
    rf[0] = 16'h0102; rf[1] = 16'h0408;
    ready_pct = 100;
    do_start(0, 1, 1'b1);
    wait_done(500);

    // Coherency: write after fetch; starts while busy and in DONE are ignored
    rf[3] = 16'h0003; rf[4] = 16'h4444;
    d0 = done_cnt;
    do_start(3, 4, 1'b1);
    @(posedge clk);
    #1;
    rf[3] = 16'h3333;
    bus.start = 1'b1; bus.first_sel = 4'd0; bus.last_sel = 4'd15;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(500);
    bus.start = 1'b1; bus.first_sel = 4'd7; bus.last_sel = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("single_done", 32'(done_cnt), 32'(d0 + 1));
    chk("idle_after_ignored", 32'(bus.busy), 32'd0);

    // Reset during SEND_B of the second word
    for (int i = 0; i < 16; i++) rf[i] = 16'hC000 + 16'(i * 16'h0101);
    ready_pct = 100;
    do_start(0, 5, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_byte", 32'(bus.out_data), 32'(rf[1][7:0]));
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_sel", 32'(bus.read_select), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_cnt), 32'(d0));
    ready_pct = 60;
    do_start(2, 4, 1'b1);
    wait_done(500);

    // Randomized ranges and contents
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
      f = $urandom_range(0, 15);
      l = $urandom_range(0, 15);
      ready_pct = $urandom_range(20, 100);
      d0 = done_cnt;
      do_start(f, l, 1'b1);
      wait_done(20 * 3 * nwords(f, l) + 50);
      chk("rand_done_once", 32'(done_cnt), 32'(d0 + 1));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
